// File: rtl/sram_serial_bridge_pkg.sv
// Shared encodings for the SRAM serial bridge: FSM state codes, R/W bit values
// and the derivation of the bank-select and command-frame widths.
package sram_serial_bridge_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_WACC   = 3'd3;
  localparam logic [2:0] S_RACC   = 3'd4;
  localparam logic [2:0] S_RCAP   = 3'd5;
  localparam logic [2:0] S_RSHIFT = 3'd6;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // A single bank still carries one select bit so the frame layout never collapses.
  function automatic int bsw_of(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

  function automatic int cmdlen_of(input int addrwidth, input int nbank);
    return 1 + bsw_of(nbank) + addrwidth;
  endfunction

endpackage

// File: rtl/sram_serial_bridge_if.sv
// Pad-side serial signals and SRAM-side bank bus of the bridge.
// master = bridge, slave = host pads plus SRAM banks.
interface sram_serial_bridge_if #(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 32,
  parameter int NBANK     = 2
);
  logic                       hostsel;
  logic                       scs;
  logic                       sdi;
  logic                       sdo;
  logic                       svalid;
  logic                       busy;
  logic                       err;
  logic [ADDRWIDTH-1:0]       sram_a;
  logic [DATAWIDTH-1:0]       sram_d;
  logic [NBANK*DATAWIDTH-1:0] sram_q;
  logic [NBANK-1:0]           sram_cen;
  logic                       sram_wen;

  modport master (
    input  hostsel, scs, sdi, sram_q,
    output sdo, svalid, busy, err, sram_a, sram_d, sram_cen, sram_wen
  );

  modport slave (
    output hostsel, scs, sdi, sram_q,
    input  sdo, svalid, busy, err, sram_a, sram_d, sram_cen, sram_wen
  );
endinterface

// File: rtl/sram_serial_bridge_serdes_reg.sv
// Shift register with parallel load, serial shift-in at the LSB and enable;
// the MSB of par_out is the serial output. Load wins over shift.
module serdes_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_out <= '0;
    end else if (load) begin
      par_out <= par_in;
    end else if (en) begin
      par_out <= {par_out[WIDTH-2:0], ser_in};
    end
  end

endmodule

// File: rtl/sram_serial_bridge.sv
// Framed serial host access to NBANK SRAM banks with auto-increment bursts and error reporting.
// Read data leaves 2 cycles after the last command bit; no backpressure, SCS framing only.
module sram_serial_bridge
  import sram_serial_bridge_pkg::*;
#(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 32,
  parameter int NBANK     = 2
) (
  input  logic CLK,
  input  logic RST,
  sram_serial_bridge_if.master bus
);

  localparam int BSW    = bsw_of(NBANK);
  localparam int CMDLEN = cmdlen_of(ADDRWIDTH, NBANK);
  localparam int MAXLEN = (CMDLEN > DATAWIDTH) ? CMDLEN : DATAWIDTH;
  localparam int CNTW   = $clog2(MAXLEN);

  logic [2:0]           state, state_nxt;
  logic [CNTW-1:0]      cnt, cnt_nxt;
  logic [CMDLEN-2:0]    cmd_sr, cmd_nxt;
  logic [CMDLEN-1:0]    cmd_full;
  logic [ADDRWIDTH-1:0] addr_q, addr_nxt;
  logic [BSW-1:0]       bank_q, bank_nxt;
  logic [DATAWIDTH-1:0] d_q, d_nxt;
  logic [NBANK-1:0]     cen_q, cen_nxt;
  logic                 wen_q, wen_nxt;
  logic                 err_q, err_nxt;
  logic                 abort, acc_nxt;
  logic                 sd_en, sd_load, sd_in;
  logic [DATAWIDTH-1:0] sd_q, q_sel;

  // Bad bank indices never match, so such reads shift out zeros.
  always_comb begin
    q_sel = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_q == BSW'(b)) q_sel = bus.sram_q[b*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd_sr;
    addr_nxt  = addr_q;
    bank_nxt  = bank_q;
    d_nxt     = d_q;
    abort     = 1'b0;
    sd_en     = 1'b0;
    sd_load   = 1'b0;
    cmd_full  = {cmd_sr, bus.sdi};
    if (!bus.hostsel) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: if (bus.scs) begin
          cmd_nxt   = cmd_full[CMDLEN-2:0];
          cnt_nxt   = CNTW'(1);
          state_nxt = S_CMD;
        end
        S_CMD: if (!bus.scs) begin
          abort = 1'b1;
        end else if (cnt == CNTW'(CMDLEN-1)) begin
          addr_nxt  = cmd_full[ADDRWIDTH-1:0];
          bank_nxt  = cmd_full[ADDRWIDTH +: BSW];
          cnt_nxt   = '0;
          state_nxt = (cmd_full[CMDLEN-1] == RW_READ) ? S_RACC : S_WDATA;
        end else begin
          cmd_nxt = cmd_full[CMDLEN-2:0];
          cnt_nxt = cnt + 1'b1;
        end
        S_WDATA: if (!bus.scs) begin
          abort = 1'b1;
        end else begin
          sd_en = 1'b1;
          if (cnt == CNTW'(DATAWIDTH-1)) begin
            d_nxt     = {sd_q[DATAWIDTH-2:0], bus.sdi};
            cnt_nxt   = '0;
            state_nxt = S_WACC;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_WACC: if (bus.scs) begin
          addr_nxt  = addr_q + 1'b1;
          state_nxt = S_WDATA;
        end else begin
          state_nxt = S_IDLE;
        end
        S_RACC: if (!bus.scs) abort = 1'b1;
                else          state_nxt = S_RCAP;
        S_RCAP: if (!bus.scs) begin
          abort = 1'b1;
        end else begin
          sd_load   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_RSHIFT;
        end
        S_RSHIFT: begin
          sd_en = 1'b1;
          if (cnt == CNTW'(DATAWIDTH-1)) begin
            cnt_nxt = '0;
            if (bus.scs) begin
              addr_nxt  = addr_q + 1'b1;
              state_nxt = S_RACC;
            end else begin
              state_nxt = S_IDLE;
            end
          end else if (!bus.scs) begin
            abort = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  // Strobes are computed from the next state so they are already stable
  // when the banks sample on the falling edge of the access cycle.
  always_comb begin
    acc_nxt = (state_nxt == S_WACC) || (state_nxt == S_RACC);
    cen_nxt = '1;
    for (int b = 0; b < NBANK; b++) begin
      if (acc_nxt && (bank_nxt == BSW'(b))) cen_nxt[b] = 1'b0;
    end
    wen_nxt = (state_nxt != S_WACC);
    err_nxt = abort || (acc_nxt && !(int'(bank_nxt) < NBANK));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      cmd_sr <= '0;
      addr_q <= '0;
      bank_q <= '0;
      d_q    <= '0;
      cen_q  <= '1;
      wen_q  <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cmd_sr <= cmd_nxt;
      addr_q <= addr_nxt;
      bank_q <= bank_nxt;
      d_q    <= d_nxt;
      cen_q  <= cen_nxt;
      wen_q  <= wen_nxt;
      err_q  <= err_nxt;
    end
  end

  assign sd_in = (state == S_WDATA) & bus.sdi;

  serdes_reg #(.WIDTH(DATAWIDTH)) u_serdes (
    .clk     (CLK),
    .rst_n   (RST),
    .en      (sd_en),
    .load    (sd_load),
    .par_in  (q_sel),
    .ser_in  (sd_in),
    .par_out (sd_q)
  );

  assign bus.sram_a   = addr_q;
  assign bus.sram_d   = d_q;
  assign bus.sram_cen = cen_q;
  assign bus.sram_wen = wen_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.svalid   = (state == S_RSHIFT);
  assign bus.sdo      = bus.svalid & sd_q[DATAWIDTH-1];

endmodule

// File: tb/tb_sram_serial_bridge.sv
// Directed bench: dut0 (NBANK=2) with a behavioural SRAM, dut1 (NBANK=3) with constant all-ones read data.
module tb_sram_serial_bridge;

  typedef struct packed {
    logic [2:0]  cen;
    logic        wen;
    logic [12:0] a;
    logic [31:0] d;
  } acc_t;

  logic clk = 1'b0, rst_n = 1'b1, scs = 1'b0, sdi = 1'b0;
  logic hostsel0 = 1'b0, hostsel1 = 1'b0;
  int   cyc = 0, n_chk = 0, n_pass = 0, last_cmd = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_serial_bridge_if #(.ADDRWIDTH(13), .DATAWIDTH(32), .NBANK(2)) b0 ();
  sram_serial_bridge_if #(.ADDRWIDTH(13), .DATAWIDTH(32), .NBANK(3)) b1 ();

  assign b0.hostsel = hostsel0;
  assign b0.scs     = scs;
  assign b0.sdi     = sdi;
  assign b1.hostsel = hostsel1;
  assign b1.scs     = scs;
  assign b1.sdi     = sdi;
  assign b1.sram_q  = '1;

  sram_serial_bridge #(.ADDRWIDTH(13), .DATAWIDTH(32), .NBANK(2)) u_dut0 (.CLK(clk), .RST(rst_n), .bus(b0));
  sram_serial_bridge #(.ADDRWIDTH(13), .DATAWIDTH(32), .NBANK(3)) u_dut1 (.CLK(clk), .RST(rst_n), .bus(b1));

  acc_t        acc0_q[$], acc1_q[$];
  logic [31:0] rd0_q[$], rd1_q[$];
  logic [31:0] mem0 [int];
  logic [31:0] q0 [2] = '{32'h0, 32'h0};
  logic [31:0] rd0_cur = '0, rd1_cur = '0;
  int err0 = 0, err1 = 0, multi = 0, sv0_first = 0, rd0_n = 0, rd1_n = 0;

  // dut0 bank model plus access/err/read-stream capture, all on the SRAM sampling edge
  always @(negedge clk) begin
    if (b0.sram_cen != 2'b11) acc0_q.push_back('{{1'b1, b0.sram_cen}, b0.sram_wen, b0.sram_a, b0.sram_d});
    if ($countones(~b0.sram_cen) > 1) multi++;
    for (int b = 0; b < 2; b++) begin
      if (!b0.sram_cen[b]) begin
        if (!b0.sram_wen) mem0[b*8192 + int'(b0.sram_a)] = b0.sram_d;
        else q0[b] = mem0.exists(b*8192 + int'(b0.sram_a)) ? mem0[b*8192 + int'(b0.sram_a)] : 32'h0;
      end
    end
    b0.sram_q = {q0[1], q0[0]};
    if (b0.err) err0++;
    if (!rst_n) rd0_n = 0;
    else if (b0.svalid) begin
      if (rd0_n % 32 == 0) sv0_first = cyc;
      rd0_cur = {rd0_cur[30:0], b0.sdo};
      rd0_n++;
      if (rd0_n % 32 == 0) rd0_q.push_back(rd0_cur);
    end
  end

  always @(negedge clk) begin
    if (b1.sram_cen != 3'b111) acc1_q.push_back('{b1.sram_cen, b1.sram_wen, b1.sram_a, b1.sram_d});
    if ($countones(~b1.sram_cen) > 1) multi++;
    if (b1.err) err1++;
    if (!rst_n) rd1_n = 0;
    else if (b1.svalid) begin
      rd1_cur = {rd1_cur[30:0], b1.sdo};
      rd1_n++;
      if (rd1_n % 32 == 0) rd1_q.push_back(rd1_cur);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    scs = 1'b0;
    sdi = 1'b0;
    repeat (n) tick();
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      scs = 1'b1;
      sdi = v[i];
      tick();
    end
  endtask

  function automatic logic [31:0] mk_cmd(input int cl, input logic rw, input int bank, input logic [12:0] addr);
    logic [31:0] c;
    c = {19'd0, addr} | (32'(bank) << 13);
    c[cl-1] = rw;
    return c;
  endfunction

  task automatic write_frame(input int cl, input int bank, input logic [12:0] addr, input int n,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    shift_bits(mk_cmd(cl, 1'b0, bank, addr), cl);
    for (int k = 0; k < n; k++) begin
      shift_bits(w[k], 32);
      scs = (k < n - 1);   // level during WACC chooses burst or end
      sdi = 1'b0;
      tick();
    end
    idle(2);
  endtask

  task automatic read_frame(input int cl, input int bank, input logic [12:0] addr, input int n);
    shift_bits(mk_cmd(cl, 1'b1, bank, addr), cl);
    last_cmd = cyc;
    sdi = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      tick();
      for (int j = 0; j < 32; j++) begin
        scs = (j < 31) || (k < n - 1);
        tick();
      end
    end
    idle(2);
  endtask

  function automatic acc_t acc0_at(input int i);
    return (acc0_q.size() > i) ? acc0_q[i] : '0;
  endfunction

  function automatic acc_t acc1_at(input int i);
    return (acc1_q.size() > i) ? acc1_q[i] : '0;
  endfunction

  initial begin
    int   ab, eb, rb, ab1, eb1, rb1;
    acc_t a;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_cen0", b0.sram_cen, 2'b11);
    check("rst_cen1", b1.sram_cen, 3'b111);
    check("rst_wen_ad", {b0.sram_wen, b0.sram_a, b0.sram_d}, {1'b1, 45'h0});
    check("rst_flags", {b0.busy, b0.svalid, b0.sdo, b0.err}, 4'b0000);
    rst_n = 1'b1;
    hostsel0 = 1'b1;
    idle(2);

    ab = acc0_q.size(); eb = err0;
    write_frame(15, 1, 13'h0010, 1, 32'hDEADBEEF, 32'h0, 32'h0);
    a = acc0_at(ab);
    check("wr_count", acc0_q.size() - ab, 1);
    check("wr_cen", a.cen[1:0], 2'b01);
    check("wr_wen", a.wen, 1'b0);
    check("wr_addr", a.a, 13'h0010);
    check("wr_data", a.d, 32'hDEADBEEF);
    check("wr_err", err0 - eb, 0);
    check("wr_busy_after", b0.busy, 1'b0);

    ab = acc0_q.size(); rb = rd0_q.size();
    read_frame(15, 1, 13'h0010, 1);
    a = acc0_at(ab);
    check("rd_count", acc0_q.size() - ab, 1);
    check("rd_cen_wen", {a.cen[1:0], a.wen}, 3'b011);
    check("rd_words", rd0_q.size() - rb, 1);
    check("rd_data", (rd0_q.size() > rb) ? rd0_q[rb] : 32'h0, 32'hDEADBEEF);
    check("rd_latency", sv0_first - last_cmd, 2);

    ab = acc0_q.size(); eb = err0;
    write_frame(15, 0, 13'h1FFF, 3, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3);
    check("bw_count", acc0_q.size() - ab, 3);
    a = acc0_at(ab);
    check("bw_0", {a.cen[1:0], a.wen, a.a, a.d}, {2'b10, 1'b0, 13'h1FFF, 32'hA1A1A1A1});
    a = acc0_at(ab + 1);
    check("bw_1", {a.cen[1:0], a.wen, a.a, a.d}, {2'b10, 1'b0, 13'h0000, 32'hB2B2B2B2});
    a = acc0_at(ab + 2);
    check("bw_2", {a.cen[1:0], a.wen, a.a, a.d}, {2'b10, 1'b0, 13'h0001, 32'hC3C3C3C3});
    check("bw_err", err0 - eb, 0);

    rb = rd0_q.size();
    read_frame(15, 0, 13'h1FFF, 2);
    check("br_words", rd0_q.size() - rb, 2);
    check("br_0", (rd0_q.size() > rb) ? rd0_q[rb] : 32'h0, 32'hA1A1A1A1);
    check("br_1", (rd0_q.size() > rb + 1) ? rd0_q[rb + 1] : 32'h0, 32'hB2B2B2B2);

    ab = acc0_q.size(); eb = err0;
    shift_bits(mk_cmd(15, 1'b0, 0, 13'h0005), 15);
    shift_bits(32'h000FFFFF, 20);
    scs = 1'b0;
    tick();
    check("ab_busy", b0.busy, 1'b0);
    check("ab_err_hi", b0.err, 1'b1);
    tick();
    check("ab_err_lo", b0.err, 1'b0);
    check("ab_nocen", acc0_q.size() - ab, 0);
    check("ab_errcnt", err0 - eb, 1);
    write_frame(15, 0, 13'h0005, 1, 32'h12345678, 32'h0, 32'h0);
    a = acc0_at(ab);
    check("ab_next", {a.cen[1:0], a.wen, a.a, a.d}, {2'b10, 1'b0, 13'h0005, 32'h12345678});

    hostsel0 = 1'b0;
    hostsel1 = 1'b1;
    ab = acc0_q.size(); eb = err0;
    ab1 = acc1_q.size(); eb1 = err1; rb1 = rd1_q.size();
    read_frame(16, 3, 13'h0022, 1);
    check("bb_nocen", acc1_q.size() - ab1, 0);
    check("bb_err", err1 - eb1, 1);
    check("bb_data", (rd1_q.size() > rb1) ? rd1_q[rb1] : 32'hFFFFFFFF, 32'h0);
    ab1 = acc1_q.size(); eb1 = err1; rb1 = rd1_q.size();
    read_frame(16, 2, 13'h0022, 1);
    a = acc1_at(ab1);
    check("b2_acc", {a.cen, a.wen, a.a}, {3'b011, 1'b1, 13'h0022});
    check("b2_data", (rd1_q.size() > rb1) ? rd1_q[rb1] : 32'h0, 32'hFFFFFFFF);
    check("b2_err", err1 - eb1, 0);
    check("hs0_ignored", {acc0_q.size() - ab, err0 - eb}, 64'h0);
    hostsel1 = 1'b0;
    hostsel0 = 1'b1;
    idle(1);

    shift_bits(mk_cmd(15, 1'b1, 1, 13'h0010), 15);
    sdi = 1'b0;
    repeat (7) tick();
    check("mid_svalid", b0.svalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_flags", {b0.busy, b0.svalid, b0.sdo, b0.err}, 4'b0000);
    check("arst_bus", {b0.sram_cen, b0.sram_wen, b0.sram_a, b0.sram_d}, {2'b11, 1'b1, 45'h0});
    scs = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(2);

    ab = acc0_q.size(); eb = err0;
    shift_bits(mk_cmd(15, 1'b0, 0, 13'h0100), 15);
    shift_bits(32'h000002AA, 10);
    hostsel0 = 1'b0;
    tick();
    check("hs_busy", b0.busy, 1'b0);
    check("hs_err", b0.err, 1'b0);
    idle(2);
    hostsel0 = 1'b1;
    idle(1);
    check("hs_noacc", {acc0_q.size() - ab, err0 - eb}, 64'h0);

    rb = rd0_q.size();
    read_frame(15, 0, 13'h0100, 1);
    check("hs_nowrite", (rd0_q.size() > rb) ? rd0_q[rb] : 32'hFFFFFFFF, 32'h0);
    rb = rd0_q.size();
    read_frame(15, 0, 13'h0005, 1);
    check("rb_after_abort", (rd0_q.size() > rb) ? rd0_q[rb] : 32'h0, 32'h12345678);
    check("one_cen", multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
